// File: rtl/rocc_cmd_queue.sv
// RoCC command queue: a DEPTH-entry FIFO between the core cmd port and the accelerator.
// It also caps the number of issued xd=1 commands whose responses have not yet returned.
module rocc_cmd_queue #(
    parameter int xLen            = 64,
    parameter int DEPTH           = 4,
    parameter int MAX_OUTSTANDING = 3
) (
    input  logic                         clock,
    input  logic                         reset_n,
    input  logic                         in_cmd_valid,
    output logic                         in_cmd_ready,
    input  logic [6:0]                   in_cmd_funct,
    input  logic [4:0]                   in_cmd_rd,
    input  logic                         in_cmd_xd,
    input  logic [xLen-1:0]              in_cmd_rs1,
    input  logic [xLen-1:0]              in_cmd_rs2,
    output logic                         out_cmd_valid,
    input  logic                         out_cmd_ready,
    output logic [6:0]                   out_cmd_funct,
    output logic [4:0]                   out_cmd_rd,
    output logic                         out_cmd_xd,
    output logic [xLen-1:0]              out_cmd_rs1,
    output logic [xLen-1:0]              out_cmd_rs2,
    input  logic                         resp_fire,
    output logic                         rocc_busy,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(MAX_OUTSTANDING + 1);

    typedef struct packed {
        logic [6:0]      funct;
        logic [4:0]      rd;
        logic            xd;
        logic [xLen-1:0] rs1;
        logic [xLen-1:0] rs2;
    } entry_t;

    entry_t          r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;
    logic [PW-1:0]   r_pending;

    entry_t          w_head;
    logic            w_full;
    logic            w_empty;
    logic            w_stall;
    logic            w_in_fire;
    logic            w_out_fire;
    logic            w_issue_xd;

    assign w_head     = r_mem[r_rd_ptr];
    assign w_full     = (r_count == CW'(DEPTH));
    assign w_empty    = (r_count == '0);
    // An xd=1 head waits for a response slot; xd=0 heads never do.
    assign w_stall    = w_head.xd && (r_pending == PW'(MAX_OUTSTANDING));
    assign w_in_fire  = in_cmd_valid && !w_full;
    assign w_out_fire = out_cmd_valid && out_cmd_ready;
    assign w_issue_xd = w_out_fire && w_head.xd;

    assign in_cmd_ready  = !w_full;
    assign out_cmd_valid = !w_empty && !w_stall;
    assign out_cmd_funct = w_head.funct;
    assign out_cmd_rd    = w_head.rd;
    assign out_cmd_xd    = w_head.xd;
    assign out_cmd_rs1   = w_head.rs1;
    assign out_cmd_rs2   = w_head.rs2;
    assign rocc_busy     = !w_empty || (r_pending != '0);
    assign count         = r_count;

    // NOTE: the data array has no reset; occupancy is tracked by r_count, so stale entries are never presented as valid.
    always_ff @(posedge clock) begin
        if (w_in_fire) begin
            r_mem[r_wr_ptr] <= {in_cmd_funct, in_cmd_rd, in_cmd_xd, in_cmd_rs1, in_cmd_rs2};
        end
    end

    // NOTE: all state updates use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_pending <= '0;
        end else begin
            if (w_in_fire) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_out_fire) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end

            case ({w_in_fire, w_out_fire})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase

            // A response with nothing owed is dropped rather than wrapping the counter.
            case ({w_issue_xd, resp_fire})
                2'b10:   r_pending <= r_pending + PW'(1);
                2'b01:   r_pending <= (r_pending != '0) ? r_pending - PW'(1) : r_pending;
                default: r_pending <= r_pending;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset_n && resp_fire) begin
            assert (r_pending != '0)
                else $error("rocc_cmd_queue: resp_fire with no response outstanding");
        end
    end

endmodule

// File: tb/tb_rocc_cmd_queue.sv
// Self-checking bench for rocc_cmd_queue: directed scenarios plus randomized traffic
// scored against a queue-based reference model.
module tb_rocc_cmd_queue;

    localparam int XLEN  = 64;
    localparam int DEPTH = 4;
    localparam int MAXO  = 3;
    localparam int CW    = $clog2(DEPTH + 1);

    typedef struct {
        logic [6:0]      funct;
        logic [4:0]      rd;
        logic            xd;
        logic [XLEN-1:0] rs1;
        logic [XLEN-1:0] rs2;
    } cmd_t;

    logic            clock;
    logic            reset_n;
    logic            in_cmd_valid;
    logic            in_cmd_ready;
    logic [6:0]      in_cmd_funct;
    logic [4:0]      in_cmd_rd;
    logic            in_cmd_xd;
    logic [XLEN-1:0] in_cmd_rs1;
    logic [XLEN-1:0] in_cmd_rs2;
    logic            out_cmd_valid;
    logic            out_cmd_ready;
    logic [6:0]      out_cmd_funct;
    logic [4:0]      out_cmd_rd;
    logic            out_cmd_xd;
    logic [XLEN-1:0] out_cmd_rs1;
    logic [XLEN-1:0] out_cmd_rs2;
    logic            resp_fire;
    logic            rocc_busy;
    logic [CW-1:0]   count;

    int   errors = 0;
    int   checks = 0;
    cmd_t q[$];
    int   m_pending = 0;

    rocc_cmd_queue #(.xLen(XLEN), .DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO)) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .in_cmd_valid  (in_cmd_valid),
        .in_cmd_ready  (in_cmd_ready),
        .in_cmd_funct  (in_cmd_funct),
        .in_cmd_rd     (in_cmd_rd),
        .in_cmd_xd     (in_cmd_xd),
        .in_cmd_rs1    (in_cmd_rs1),
        .in_cmd_rs2    (in_cmd_rs2),
        .out_cmd_valid (out_cmd_valid),
        .out_cmd_ready (out_cmd_ready),
        .out_cmd_funct (out_cmd_funct),
        .out_cmd_rd    (out_cmd_rd),
        .out_cmd_xd    (out_cmd_xd),
        .out_cmd_rs1   (out_cmd_rs1),
        .out_cmd_rs2   (out_cmd_rs2),
        .resp_fire     (resp_fire),
        .rocc_busy     (rocc_busy),
        .count         (count)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic set_cmd(input logic [6:0] f, input logic [4:0] r, input logic x,
                           input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
        in_cmd_funct = f;
        in_cmd_rd    = r;
        in_cmd_xd    = x;
        in_cmd_rs1   = a;
        in_cmd_rs2   = b;
    endtask

    // Scores the current cycle against the model, advances the model, then steps one clock.
    task automatic clock_and_score();
        int   exp_count;
        bit   exp_ready, exp_valid, exp_busy, in_fire, out_fire;
        cmd_t c;
        exp_count = q.size();
        exp_ready = (exp_count != DEPTH);
        exp_valid = (exp_count > 0) && !(q[0].xd && m_pending == MAXO);
        exp_busy  = (exp_count > 0) || (m_pending > 0);

        checks++;
        if (in_cmd_ready !== exp_ready) begin
            errors++;
            $display("FAIL in_cmd_ready @%0t: got %b expected %b", $time, in_cmd_ready, exp_ready);
        end
        checks++;
        if (out_cmd_valid !== exp_valid) begin
            errors++;
            $display("FAIL out_cmd_valid @%0t: got %b expected %b", $time, out_cmd_valid, exp_valid);
        end
        checks++;
        if (rocc_busy !== exp_busy) begin
            errors++;
            $display("FAIL rocc_busy @%0t: got %b expected %b", $time, rocc_busy, exp_busy);
        end
        checks++;
        if (count !== CW'(exp_count)) begin
            errors++;
            $display("FAIL count @%0t: got %0d expected %0d", $time, count, exp_count);
        end
        if (exp_count > 0) begin
            checks++;
            if ({out_cmd_funct, out_cmd_rd, out_cmd_xd, out_cmd_rs1, out_cmd_rs2} !==
                {q[0].funct, q[0].rd, q[0].xd, q[0].rs1, q[0].rs2}) begin
                errors++;
                $display("FAIL head_fields @%0t: got f=%0d rd=%0d xd=%b rs1=%0h rs2=%0h expected f=%0d rd=%0d xd=%b rs1=%0h rs2=%0h",
                         $time, out_cmd_funct, out_cmd_rd, out_cmd_xd, out_cmd_rs1, out_cmd_rs2,
                         q[0].funct, q[0].rd, q[0].xd, q[0].rs1, q[0].rs2);
            end
        end

        in_fire  = in_cmd_valid && exp_ready;
        out_fire = exp_valid && out_cmd_ready;
        if (out_fire) begin
            if (q[0].xd) m_pending++;
            void'(q.pop_front());
        end
        if (resp_fire && m_pending > 0) m_pending--;
        if (in_fire) begin
            c.funct = in_cmd_funct;
            c.rd    = in_cmd_rd;
            c.xd    = in_cmd_xd;
            c.rs1   = in_cmd_rs1;
            c.rs2   = in_cmd_rs2;
            q.push_back(c);
        end
        @(posedge clock);
        #1;
    endtask

    task automatic push_cmd(input logic x, input logic [XLEN-1:0] a);
        set_cmd(7'($urandom), 5'($urandom), x, a, {$urandom, $urandom});
        in_cmd_valid = 1'b1;
        clock_and_score();
        in_cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset_n       = 1'b0;
        in_cmd_valid  = 1'b1;
        out_cmd_ready = 1'b0;
        resp_fire     = 1'b0;
        set_cmd(7'd1, 5'd2, 1'b1, 64'd3, 64'd4);
        repeat (2) begin
            @(posedge clock);
            #1;
        end
        checks++;
        if (in_cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", in_cmd_ready); end
        checks++;
        if (out_cmd_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", out_cmd_valid); end
        checks++;
        if (count !== '0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count); end
        checks++;
        if (rocc_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", rocc_busy); end
        reset_n      = 1'b1;
        in_cmd_valid = 1'b0;
        q.delete();
        m_pending = 0;
        clock_and_score();
    endtask

    task automatic test_single_pass();
        out_cmd_ready = 1'b0;
        set_cmd(7'd3, 5'd7, 1'b1, 64'd5, 64'd9);
        in_cmd_valid = 1'b1;
        clock_and_score();
        in_cmd_valid = 1'b0;
        checks++;
        if ({out_cmd_valid, out_cmd_funct, out_cmd_rd, out_cmd_xd, out_cmd_rs1, out_cmd_rs2} !==
            {1'b1, 7'd3, 5'd7, 1'b1, 64'd5, 64'd9}) begin
            errors++;
            $display("FAIL single_head: got v=%b f=%0d rd=%0d xd=%b rs1=%0d rs2=%0d expected v=1 f=3 rd=7 xd=1 rs1=5 rs2=9",
                     out_cmd_valid, out_cmd_funct, out_cmd_rd, out_cmd_xd, out_cmd_rs1, out_cmd_rs2);
        end
        out_cmd_ready = 1'b1;
        clock_and_score();
        out_cmd_ready = 1'b0;
        checks++;
        if (rocc_busy !== 1'b1 || count !== '0) begin
            errors++;
            $display("FAIL single_issued: got busy=%b count=%0d expected busy=1 count=0", rocc_busy, count);
        end
        resp_fire = 1'b1;
        clock_and_score();
        resp_fire = 1'b0;
        checks++;
        if (rocc_busy !== 1'b0) begin errors++; $display("FAIL single_resp_busy: got %b expected 0", rocc_busy); end
    endtask

    task automatic test_fill();
        out_cmd_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) push_cmd(1'b0, 64'(100 + i));
        checks++;
        if (in_cmd_ready !== 1'b0 || count !== CW'(DEPTH)) begin
            errors++;
            $display("FAIL fill_full: got ready=%b count=%0d expected ready=0 count=%0d", in_cmd_ready, count, DEPTH);
        end
        push_cmd(1'b0, 64'd999);
        out_cmd_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            checks++;
            if (out_cmd_rs1 !== 64'(100 + i)) begin
                errors++;
                $display("FAIL fill_drain_order: got %0d expected %0d", out_cmd_rs1, 100 + i);
            end
            clock_and_score();
        end
        out_cmd_ready = 1'b0;
        for (int i = 0; i < 3; i++) push_cmd(1'b0, 64'(200 + i));
        out_cmd_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (out_cmd_rs1 !== 64'(200 + i)) begin
                errors++;
                $display("FAIL wrap_drain_order: got %0d expected %0d", out_cmd_rs1, 200 + i);
            end
            clock_and_score();
        end
        out_cmd_ready = 1'b0;
    endtask

    task automatic test_full_simultaneous();
        out_cmd_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) push_cmd(1'b0, 64'(500 + i));
        set_cmd(7'd9, 5'd9, 1'b0, 64'd600, 64'd601);
        in_cmd_valid  = 1'b1;
        out_cmd_ready = 1'b1;
        clock_and_score();
        checks++;
        if (count !== CW'(DEPTH - 1)) begin errors++; $display("FAIL full_simul_count: got %0d expected %0d", count, DEPTH - 1); end
        out_cmd_ready = 1'b0;
        clock_and_score();
        in_cmd_valid = 1'b0;
        checks++;
        if (count !== CW'(DEPTH) || in_cmd_ready !== 1'b0) begin
            errors++;
            $display("FAIL full_refill: got count=%0d ready=%b expected count=%0d ready=0", count, in_cmd_ready, DEPTH);
        end
        out_cmd_ready = 1'b1;
        repeat (DEPTH) clock_and_score();
        out_cmd_ready = 1'b0;
    endtask

    task automatic test_outstanding_cap();
        out_cmd_ready = 1'b0;
        for (int i = 0; i < 4; i++) push_cmd(1'b1, 64'(300 + i));
        out_cmd_ready = 1'b1;
        repeat (3) clock_and_score();
        checks++;
        if (out_cmd_valid !== 1'b0) begin errors++; $display("FAIL cap_stall: got valid=%b expected 0", out_cmd_valid); end
        push_cmd(1'b0, 64'd400);
        checks++;
        if (out_cmd_valid !== 1'b0 || count !== CW'(2)) begin
            errors++;
            $display("FAIL cap_blocks_younger: got valid=%b count=%0d expected valid=0 count=2", out_cmd_valid, count);
        end
        resp_fire = 1'b1;
        clock_and_score();
        resp_fire = 1'b0;
        checks++;
        if (out_cmd_valid !== 1'b1 || out_cmd_rs1 !== 64'd303) begin
            errors++;
            $display("FAIL cap_release: got valid=%b rs1=%0d expected valid=1 rs1=303", out_cmd_valid, out_cmd_rs1);
        end
        clock_and_score();
        checks++;
        if (out_cmd_valid !== 1'b1 || out_cmd_rs1 !== 64'd400) begin
            errors++;
            $display("FAIL cap_xd0_issues: got valid=%b rs1=%0d expected valid=1 rs1=400", out_cmd_valid, out_cmd_rs1);
        end
        clock_and_score();
        out_cmd_ready = 1'b0;
        resp_fire     = 1'b1;
        repeat (MAXO) clock_and_score();
        resp_fire = 1'b0;
        checks++;
        if (rocc_busy !== 1'b0) begin errors++; $display("FAIL cap_idle_busy: got %b expected 0", rocc_busy); end
    endtask

    task automatic test_mid_reset();
        out_cmd_ready = 1'b0;
        push_cmd(1'b1, 64'd700);
        push_cmd(1'b1, 64'd701);
        out_cmd_ready = 1'b1;
        repeat (2) clock_and_score();
        out_cmd_ready = 1'b0;
        push_cmd(1'b0, 64'd702);
        push_cmd(1'b0, 64'd703);
        checks++;
        if (count !== CW'(2) || rocc_busy !== 1'b1) begin
            errors++;
            $display("FAIL midreset_setup: got count=%0d busy=%b expected count=2 busy=1", count, rocc_busy);
        end
        reset_n   = 1'b0;
        resp_fire = 1'b1;
        @(posedge clock);
        #1;
        reset_n   = 1'b1;
        resp_fire = 1'b0;
        q.delete();
        m_pending = 0;
        checks++;
        if (count !== '0 || rocc_busy !== 1'b0 || out_cmd_valid !== 1'b0 || in_cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL midreset_state: got count=%0d busy=%b valid=%b ready=%b expected 0 0 0 1",
                     count, rocc_busy, out_cmd_valid, in_cmd_ready);
        end
        repeat (2) clock_and_score();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            set_cmd(7'($urandom), 5'($urandom), 1'($urandom), {$urandom, $urandom}, {$urandom, $urandom});
            in_cmd_valid  = ($urandom_range(0, 2) != 0);
            out_cmd_ready = ($urandom_range(0, 2) != 0);
            resp_fire     = (m_pending > 0) && ($urandom_range(0, 2) == 0);
            clock_and_score();
        end
        in_cmd_valid  = 1'b0;
        out_cmd_ready = 1'b1;
        resp_fire     = 1'b0;
        repeat (DEPTH + 1) clock_and_score();
        while (m_pending > 0) begin
            resp_fire = 1'b1;
            clock_and_score();
        end
        resp_fire     = 1'b0;
        out_cmd_ready = 1'b0;
        clock_and_score();
    endtask

    initial begin
        test_reset();
        test_single_pass();
        test_fill();
        test_full_simultaneous();
        test_outstanding_cap();
        test_mid_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
